csr_commit_buffer: RTL

Holds the speculative CSR writes produced by the control-ALU execute stage until the owning instruction retires from the Active List. Each write is released to the CSR file exactly once, in program order, on commit. All still-pending writes are discarded on recovery. The block sits between the control execute pipe (producer) and the CSR register file (consumer), so no CSR state is ever modified by a squashed instruction.

---
 rtl/csr_commit_buffer_pkg.sv | 23 ++
 rtl/csr_buf_fifo.sv | 60 ++++++
 rtl/csr_commit_buffer.sv | 79 +++++++
 3 files changed

// File: rtl/csr_commit_buffer_pkg.sv
// Shared types for the CSR commit buffer: the pending-write entry layout and the default depth.
// Width macros normally come from the core's global defines; fallbacks keep this slice standalone.
`ifndef CSR_WIDTH
`define CSR_WIDTH 32
`endif
`ifndef CSR_WIDTH_LOG
`define CSR_WIDTH_LOG 12
`endif
`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 7
`endif

package csr_commit_buffer_pkg;

    localparam int CSR_BUF_DEPTH = 4;

    typedef struct packed {
        logic [`CSR_WIDTH_LOG-1:0]       addr;
        logic [`CSR_WIDTH-1:0]           data;
        logic [`SIZE_ACTIVELIST_LOG-1:0] al_id;
    } csr_buf_entry;

endpackage

// File: rtl/csr_buf_fifo.sv
// Circular store of pending CSR writes with head/tail pointers and occupancy count.
// A flush takes effect after any same-cycle pop, leaving the buffer empty at pointer 0.
module csr_buf_fifo
    import csr_commit_buffer_pkg::*;
#(
    parameter int DEPTH = CSR_BUF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  csr_buf_entry       push_entry,
    input  logic               pop,
    input  logic               flush,
    output csr_buf_entry       head_entry,
    output logic [PTR_W:0]     count,
    output logic               full
);

    csr_buf_entry        mem [DEPTH];
    logic [PTR_W-1:0]    head_q;
    logic [PTR_W-1:0]    tail_q;
    logic [PTR_W:0]      count_q;

    // Entry contents need no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PTR_W+1)'(1);
            end
        end
    end

    assign head_entry = mem[head_q];
    assign count      = count_q;
    assign full       = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/csr_commit_buffer.sv
// Holds speculative CSR writes until their instruction retires, then releases them in order.
// Recovery squashes everything still pending so a squashed instruction never touches CSR state.
module csr_commit_buffer
    import csr_commit_buffer_pkg::*;
#(
    parameter int DEPTH  = CSR_BUF_DEPTH,
    parameter int DATA_W = `CSR_WIDTH,
    parameter int ADDR_W = `CSR_WIDTH_LOG,
    parameter int ALID_W = `SIZE_ACTIVELIST_LOG
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     exeValid_i,
    input  logic                     csrWrEn_i,
    input  logic [ADDR_W-1:0]        csrWrAddr_i,
    input  logic [DATA_W-1:0]        csrWrData_i,
    input  logic [ALID_W-1:0]        alId_i,
    output logic                     full_o,
    input  logic                     commitValid_i,
    input  logic [ALID_W-1:0]        commitAlId_i,
    input  logic                     recover_i,
    output logic                     csrWrEn_o,
    output logic [ADDR_W-1:0]        csrWrAddr_o,
    output logic [DATA_W-1:0]        csrWrData_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    logic           enq_req;
    logic           push;
    logic           pop;
    logic           full;
    logic [$clog2(DEPTH):0] count;
    csr_buf_entry   push_entry;
    csr_buf_entry   head_entry;

    // A commit only pops when it retires the instruction that owns the oldest pending write.
    assign enq_req    = exeValid_i & csrWrEn_i & ~recover_i;
    assign pop        = commitValid_i & (count != '0) & (head_entry.al_id == commitAlId_i);
    assign push       = enq_req & (~full | pop);
    assign push_entry = '{addr: csrWrAddr_i, data: csrWrData_i, al_id: alId_i};

    csr_buf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (recover_i),
        .head_entry (head_entry),
        .count      (count),
        .full       (full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csrWrEn_o   <= 1'b0;
            csrWrAddr_o <= '0;
            csrWrData_o <= '0;
            overflow_o  <= 1'b0;
        end else begin
            csrWrEn_o <= pop;
            if (pop) begin
                csrWrAddr_o <= head_entry.addr;
                csrWrData_o <= head_entry.data;
            end
            // Sticky until reset; recovery deliberately leaves it set.
            if (enq_req && full && !pop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    assign full_o  = full;
    assign count_o = count;

endmodule
